// File: rtl/spi_arb_if.sv
// Client, arbiter and SPI-master signals of the shared SPI arbiter.
// slave is the arbiter side; master is the side that drives requests and the SPI master.
interface spi_arb_if;
    logic        req_inrt;
    logic [15:0] cmd_inrt;
    logic        done_inrt;
    logic [15:0] resp_inrt;
    logic        req_a2d;
    logic [15:0] cmd_a2d;
    logic        done_a2d;
    logic [15:0] resp_a2d;
    logic        err;
    logic        snd;
    logic [15:0] cmd;
    logic        spi_done;
    logic [15:0] spi_resp;
    logic        busy;
    logic        owner;

    modport slave (
        input  req_inrt, cmd_inrt, req_a2d, cmd_a2d, spi_done, spi_resp,
        output done_inrt, resp_inrt, done_a2d, resp_a2d, err, snd, cmd, busy, owner
    );
    modport master (
        output req_inrt, cmd_inrt, req_a2d, cmd_a2d, spi_done, spi_resp,
        input  done_inrt, resp_inrt, done_a2d, resp_a2d, err, snd, cmd, busy, owner
    );
endinterface

// File: rtl/spi_arb.sv
// Two-client (inertial / A2D) arbiter for one shared SPI master, with an
// A2D anti-starvation limit, a WAIT timeout and an enforced inter-transaction gap.
module spi_arb #(
    parameter int MAX_CONSEC = 4,
    parameter int TIMEOUT    = 1024,
    parameter int GAP        = 2
) (
    input  logic     clk,
    input  logic     rst_n,
    spi_arb_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int GW = $clog2(GAP + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_GAP} state_t;

    state_t           state, nstate;
    logic [1:0]       pend, req, gvec, done;
    logic [1:0][15:0] hold, cin, resp;
    logic [2:0]       consec_cnt;
    logic [TW-1:0]    tmo_cnt;
    logic [GW-1:0]    gap_cnt;
    logic [15:0]      cmd_q;
    logic             owner_q, err_q, grant, gnt_a2d, wait_done, wait_tmo;

    // index 0 = inertial, 1 = A2D
    assign req = {bus.req_a2d, bus.req_inrt};
    assign cin = {bus.cmd_a2d, bus.cmd_inrt};

    assign gnt_a2d   = pend[1] & (~pend[0] | (consec_cnt == 3'(MAX_CONSEC)));
    assign grant     = (state == S_IDLE) & (|pend);
    assign gvec      = grant ? (gnt_a2d ? 2'b10 : 2'b01) : 2'b00;
    assign wait_done = (state == S_WAIT) & bus.spi_done;
    assign wait_tmo  = (state == S_WAIT) & ~bus.spi_done & (tmo_cnt == TW'(TIMEOUT - 1));

    always_comb begin
        nstate = state;
        case (state)
            S_IDLE:  if (grant) nstate = S_ISSUE;
            S_ISSUE: nstate = S_WAIT;
            S_WAIT:  if (wait_done || wait_tmo) nstate = S_GAP;
            S_GAP:   if (gap_cnt == GW'(GAP - 1)) nstate = S_IDLE;
            default: nstate = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= nstate;
    end

    // a request landing on the grant cycle re-arms pending with its new command
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= '0;
            hold <= '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (gvec[k]) begin
                    pend[k] <= req[k];
                    if (req[k]) hold[k] <= cin[k];
                end else if (req[k] && !pend[k]) begin
                    pend[k] <= 1'b1;
                    hold[k] <= cin[k];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            consec_cnt <= '0;
            cmd_q      <= '0;
            owner_q    <= 1'b0;
        end else if (grant) begin
            cmd_q   <= gnt_a2d ? hold[1] : hold[0];
            owner_q <= gnt_a2d;
            if (gnt_a2d)
                consec_cnt <= '0;
            else if (pend[1] && consec_cnt != 3'(MAX_CONSEC))
                consec_cnt <= consec_cnt + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
            gap_cnt <= '0;
        end else begin
            if (state == S_ISSUE)                    tmo_cnt <= '0;
            else if (state == S_WAIT && !bus.spi_done) tmo_cnt <= tmo_cnt + TW'(1);
            if (state == S_WAIT)     gap_cnt <= '0;
            else if (state == S_GAP) gap_cnt <= gap_cnt + GW'(1);
        end
    end

    // completion wins over a timeout landing on the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp  <= '0;
            done  <= '0;
            err_q <= 1'b0;
        end else begin
            done  <= '0;
            err_q <= wait_tmo;
            if (wait_done) begin
                resp[owner_q] <= bus.spi_resp;
                done[owner_q] <= 1'b1;
            end else if (wait_tmo) begin
                resp[owner_q] <= 16'hFFFF;
                done[owner_q] <= 1'b1;
            end
        end
    end

    assign bus.snd       = (state == S_ISSUE);
    assign bus.busy      = (state != S_IDLE);
    assign bus.cmd       = cmd_q;
    assign bus.owner     = owner_q;
    assign bus.err       = err_q;
    assign bus.done_inrt = done[0];
    assign bus.done_a2d  = done[1];
    assign bus.resp_inrt = resp[0];
    assign bus.resp_a2d  = resp[1];
endmodule
